ram_loader: RTL

RAM_LOADER -- requirements
Module: ram_loader

---
 rtl/ram_loader.sv | 68 ++++++
 1 files changed

// File: rtl/ram_loader.sv
// ram_loader: streams MEMORY_SIZE words from a valid/ready source into a RAM
// through a shared address/data bus, using an address cycle followed by a write cycle.
module ram_loader #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int WIDTH         = 8,
  parameter int MEMORY_SIZE   = 1 << ADDRESS_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic             byte_valid,
  input  logic [WIDTH-1:0] byte_data,
  output logic             byte_ready,
  output logic [WIDTH-1:0] bus_out,
  output logic             ram_addr_enable,
  output logic             ram_write_enable,
  output logic             busy,
  output logic             done
);
  typedef enum logic [2:0] {IDLE, WAIT_BYTE, LOAD_ADDR, WRITE, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic last;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    last    = addr_q == ADDRESS_WIDTH'(MEMORY_SIZE - 1);
    case (state_q)
      IDLE: if (start) begin
        state_d = WAIT_BYTE;
        addr_d  = '0;
      end
      WAIT_BYTE: if (byte_valid) begin
        state_d = LOAD_ADDR;
        data_d  = byte_data;
      end
      LOAD_ADDR: state_d = WRITE;
      WRITE: begin
        state_d = last ? DONE : WAIT_BYTE;
        addr_d  = last ? addr_q : addr_q + 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // abort wins over every transition; the current WRITE cycle has already driven the RAM
    if (abort && state_q != IDLE) state_d = IDLE;
  end
  assign byte_ready       = state_q == WAIT_BYTE;
  assign ram_addr_enable  = state_q == LOAD_ADDR;
  assign ram_write_enable = state_q == WRITE;
  assign busy             = state_q != IDLE;
  assign done             = state_q == DONE;
  assign bus_out          = state_q == LOAD_ADDR ? WIDTH'(addr_q) :
                            state_q == WRITE     ? data_q : '0;
endmodule
